// File: rtl/fifo_word_packer.sv
// Read-side FIFO consumer that packs BYTES consecutive DATA_W-bit bytes into one word, LSB first.
// Optional build macro FIFO_WORD_PACKER_SEQ_CHECK_EN adds a sticky seq_err for non-incrementing bytes.
module fifo_word_packer #(
  parameter int DATA_W = 8,
  parameter int BYTES  = 4
) (
  input  logic                    rclk,
  input  logic                    reset,
  input  logic                    empty_bar,
  input  logic [DATA_W-1:0]       data_out,
  output logic                    ren,
  input  logic                    flush,
  output logic [DATA_W*BYTES-1:0] word_out,
  output logic [BYTES-1:0]        word_keep,
  output logic                    word_valid,
  input  logic                    word_ready,
  output logic                    state_dbg
`ifdef FIFO_WORD_PACKER_SEQ_CHECK_EN
  ,
  output logic                    seq_err
`endif
);

  localparam int CNT_W = $clog2(BYTES) + 1;

  typedef enum logic {FILL = 1'b0, FLUSH = 1'b1} state_t;

  state_t                         state;
  logic [CNT_W-1:0]               accum_cnt;
  logic [CNT_W-1:0]               slots_used;
  logic                           rd_pend;
  logic                           out_free;
  logic                           completing;
  logic                           flush_pend;
  logic [BYTES-1:0][DATA_W-1:0]   accum;
  logic [BYTES-1:0][DATA_W-1:0]   cap_word;
  logic [BYTES-1:0][DATA_W-1:0]   flush_word;
  logic [BYTES-1:0]               flush_keep;

  // Downstream handshake: word_out/word_keep are held stable while word_valid=1, and a word
  // transfers on any rclk edge where word_valid && word_ready are both 1.
  always_comb begin
    out_free   = !word_valid || word_ready;
    completing = rd_pend && (accum_cnt == CNT_W'(BYTES - 1));
    flush_pend = (state == FLUSH);
    // A completing in-flight byte frees the whole accumulator at this edge, so the next
    // word starts at slot 0 and the pop stream stays at one byte per cycle.
    slots_used = completing ? '0 : accum_cnt + CNT_W'(rd_pend);
    ren = reset && empty_bar && !flush_pend &&
          ((slots_used < CNT_W'(BYTES - 1)) ||
           ((slots_used == CNT_W'(BYTES - 1)) && out_free));
    cap_word   = accum;
    flush_word = '0;
    flush_keep = '0;
    for (int k = 0; k < BYTES; k++) begin
      if (CNT_W'(k) == accum_cnt) cap_word[k] = data_out;
      if (CNT_W'(k) < accum_cnt) begin
        flush_word[k] = accum[k];
        flush_keep[k] = 1'b1;
      end
    end
  end

  assign state_dbg = (state == FLUSH);

  always_ff @(posedge rclk or negedge reset) begin
    if (!reset) begin
      state      <= FILL;
      accum_cnt  <= '0;
      rd_pend    <= 1'b0;
      accum      <= '0;
      word_out   <= '0;
      word_keep  <= '0;
      word_valid <= 1'b0;
    end else begin
      rd_pend <= ren;
      if (word_valid && word_ready) word_valid <= 1'b0;

      if (rd_pend) begin
        accum <= cap_word;
        if (completing) begin
          word_out   <= cap_word;
          word_keep  <= '1;
          word_valid <= 1'b1;
          accum_cnt  <= '0;
        end else begin
          accum_cnt <= accum_cnt + CNT_W'(1);
        end
      end

      case (state)
        FILL: begin
          if (flush && (slots_used != '0)) state <= FLUSH;
        end
        FLUSH: begin
          // An in-flight byte that completed a word already satisfied the flush.
          if (!rd_pend && out_free) begin
            if (accum_cnt != '0) begin
              word_out   <= flush_word;
              word_keep  <= flush_keep;
              word_valid <= 1'b1;
              accum_cnt  <= '0;
            end
            state <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

`ifdef FIFO_WORD_PACKER_SEQ_CHECK_EN
  logic [DATA_W-1:0] prev_byte;
  logic              have_prev;

  always_ff @(posedge rclk or negedge reset) begin
    if (!reset) begin
      prev_byte <= '0;
      have_prev <= 1'b0;
      seq_err   <= 1'b0;
    end else if (rd_pend) begin
      prev_byte <= data_out;
      have_prev <= 1'b1;
      if (have_prev && (data_out != DATA_W'(prev_byte + DATA_W'(1)))) seq_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_word_packer.sv
// Self-checking bench for fifo_word_packer: queue-based FIFO source, byte-stream word model,
// directed literal checks and a randomized phase with flushes and backpressure.
module tb_fifo_word_packer;
  localparam int DATA_W = 8;
  localparam int BYTES  = 4;
  localparam int W      = DATA_W * BYTES;

  logic              rclk = 1'b0;
  logic              reset = 1'b0;
  logic              empty_bar = 1'b0;
  logic [DATA_W-1:0] data_out = '0;
  logic              flush = 1'b0;
  logic              word_ready = 1'b0;
  logic              ren;
  logic [W-1:0]      word_out;
  logic [BYTES-1:0]  word_keep;
  logic              word_valid;
  logic              state_dbg;
`ifdef FIFO_WORD_PACKER_SEQ_CHECK_EN
  logic              seq_err;
`endif

  fifo_word_packer #(.DATA_W(DATA_W), .BYTES(BYTES)) dut (
    .rclk(rclk), .reset(reset), .empty_bar(empty_bar), .data_out(data_out), .ren(ren),
    .flush(flush), .word_out(word_out), .word_keep(word_keep), .word_valid(word_valid),
    .word_ready(word_ready), .state_dbg(state_dbg)
`ifdef FIFO_WORD_PACKER_SEQ_CHECK_EN
    , .seq_err(seq_err)
`endif
  );

  // ---------------- clock ----------------
  always #5 rclk = ~rclk;

  int n_chk = 0;
  int n_fail = 0;
  logic [DATA_W-1:0]  src_q[$];
  logic [DATA_W-1:0]  part[$];
  logic [W+BYTES-1:0] exp_q[$];
  logic [W+BYTES-1:0] acc_log[$];
  int ren_cnt = 0, ren_run = 0, ren_max = 0;
  logic ren_s = 1'b0, hold_v = 1'b0;
  logic [W-1:0]     hold_w = '0;
  logic [BYTES-1:0] hold_k = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W+BYTES-1:0] pack_part(input int n);
    logic [W-1:0] w = '0;
    for (int i = 0; i < n; i++) w[i*DATA_W +: DATA_W] = part[i];
    return {BYTES'((1 << n) - 1), w};
  endfunction

  // FIFO source: a pop requested at an edge presents its byte just after that edge.
  always @(posedge rclk) begin
    #1;
    if (ren_s && reset && src_q.size() > 0) data_out = src_q.pop_front();
    empty_bar = (src_q.size() != 0);
  end

  // Monitor / scoreboard: samples at the falling edge the values the next rising edge will see.
  always @(negedge rclk) begin
    if (!reset) begin
      part.delete();
      exp_q.delete();
      ren_s  = 1'b0;
      hold_v = 1'b0;
    end else begin
      int cnt_before;
      if (hold_v) begin
        check("hold_valid", word_valid, 1'b1);
        check("hold_word", {word_keep, word_out}, {hold_k, hold_w});
      end
      if (word_valid && word_ready) begin
        acc_log.push_back({word_keep, word_out});
        if (exp_q.size() == 0) check("unexpected_word", {word_keep, word_out}, 64'hDEAD);
        else check("sb_word", {word_keep, word_out}, exp_q.pop_front());
      end
      hold_v = word_valid && !word_ready;
      hold_w = word_out;
      hold_k = word_keep;
      check("no_pop_when_empty", ren && !empty_bar, 1'b0);

      cnt_before = part.size();
      if (ren) begin
        ren_cnt++;
        ren_run++;
        if (ren_run > ren_max) ren_max = ren_run;
        if (src_q.size() > 0) part.push_back(src_q[0]);
        if (part.size() == BYTES) begin
          exp_q.push_back(pack_part(BYTES));
          part.delete();
        end
      end else begin
        ren_run = 0;
      end
      if (flush && cnt_before > 0 && part.size() > 0) begin
        exp_q.push_back(pack_part(part.size()));
        part.delete();
      end
      ren_s = ren;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic push(input logic [DATA_W-1:0] b);
    src_q.push_back(b);
    empty_bar = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    flush = 1'b0;
    word_ready = 1'b0;
    src_q.delete();
    empty_bar = 1'b0;
    repeat (2) tick();
    check("rst_word_valid", word_valid, 1'b0);
    check("rst_word_out", word_out, '0);
    check("rst_word_keep", word_keep, '0);
    check("rst_ren", ren, 1'b0);
    check("rst_state", state_dbg, 1'b0);
`ifdef FIFO_WORD_PACKER_SEQ_CHECK_EN
    check("rst_seq_err", seq_err, 1'b0);
`endif
    acc_log.delete();
    ren_cnt = 0;
    ren_run = 0;
    ren_max = 0;
    reset = 1'b1;
    tick();
  endtask

  task automatic check_acc(input string name, input int idx, input logic [W+BYTES-1:0] exp);
    if (idx < acc_log.size()) check(name, acc_log[idx], exp);
    else check({name, "_missing"}, acc_log.size(), idx + 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cool;
    // Full-rate stream with a free output.
    do_reset();
    word_ready = 1'b1;
    for (int i = 1; i <= 8; i++) push(8'(i));
    repeat (12) tick();
    check("t1_ren_count", ren_cnt, 8);
    check("t1_ren_burst", ren_max, 8);
    check("t1_count", acc_log.size(), 2);
    check_acc("t1_word0", 0, {4'hF, 32'h04030201});
    check_acc("t1_word1", 1, {4'hF, 32'h08070605});
    check("t1_ren_idle", ren, 1'b0);

    // Backpressure: first word held, final byte of the next word not requested.
    do_reset();
    for (int i = 1; i <= 8; i++) push(8'(i));
    repeat (12) tick();
    @(negedge rclk);
    check("t2_held_valid", word_valid, 1'b1);
    check("t2_held_word", {word_keep, word_out}, {4'hF, 32'h04030201});
    check("t2_ren_count", ren_cnt, 7);
    check("t2_ren_blocked", ren, 1'b0);
    tick();
    word_ready = 1'b1;
    repeat (6) tick();
    check("t2_count", acc_log.size(), 2);
    check_acc("t2_word0", 0, {4'hF, 32'h04030201});
    check_acc("t2_word1", 1, {4'hF, 32'h08070605});

    // Flush while the second byte is in flight.
    do_reset();
    word_ready = 1'b1;
    push(8'h0A);
    push(8'h0B);
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    push(8'h0C);
    @(negedge rclk);
    check("t3_ren_in_flush", ren, 1'b0);
    check("t3_state_flush", state_dbg, 1'b1);
    tick();
    @(negedge rclk);
    check("t3_partial_valid", word_valid, 1'b1);
    check("t3_partial_word", {word_keep, word_out}, {4'b0011, 32'h00000B0A});
    repeat (4) tick();
    check_acc("t3_word0", 0, {4'b0011, 32'h00000B0A});

    // Flush with nothing accumulated is ignored.
    do_reset();
    word_ready = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge rclk);
    check("t4_state_fill", state_dbg, 1'b0);
    repeat (3) tick();
    check("t4_no_valid", word_valid, 1'b0);
    check("t4_no_words", acc_log.size(), 0);

    // Asynchronous reset with a held word and a partial accumulator.
    do_reset();
    for (int i = 0; i < 7; i++) push(8'(8'h10 + i));
    repeat (10) tick();
    check("t5_pre_valid", word_valid, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check("t5_async_valid", word_valid, 1'b0);
    check("t5_async_word", {word_keep, word_out}, '0);
    check("t5_async_ren", ren, 1'b0);
    repeat (2) tick();
    acc_log.delete();
    reset = 1'b1;
    tick();
    word_ready = 1'b1;
    for (int i = 0; i < 4; i++) push(8'(8'h20 + i));
    repeat (8) tick();
    check("t5_count", acc_log.size(), 1);
    check_acc("t5_word0", 0, {4'hF, 32'h23222120});

`ifdef FIFO_WORD_PACKER_SEQ_CHECK_EN
    do_reset();
    word_ready = 1'b1;
    push(8'hFE);
    push(8'hFF);
    push(8'h00);
    push(8'h02);
    repeat (4) tick();
    @(negedge rclk);
    check("t6_seq_wrap_ok", seq_err, 1'b0);
    repeat (2) tick();
    @(negedge rclk);
    check("t6_seq_err_set", seq_err, 1'b1);
    repeat (4) tick();
    @(negedge rclk);
    check("t6_seq_err_sticky", seq_err, 1'b1);
    check_acc("t6_word0", 0, {4'hF, 32'h0200FFFE});
`endif

    // Randomized traffic with backpressure and spaced flush pulses.
    do_reset();
    cool = 0;
    for (int phase = 0; phase < 3; phase++) begin
      repeat (1500) begin
        if (src_q.size() < 12 && $urandom_range(0, 9) < (phase == 1 ? 9 : 5))
          push(8'($urandom_range(0, 255)));
        if (cool > 0) begin
          cool--;
          word_ready = 1'b1;
          flush = 1'b0;
        end else begin
          word_ready = (phase == 1) ? 1'b1 : ($urandom_range(0, 3) != 0);
          if ($urandom_range(0, 19) == 0) begin
            flush = 1'b1;
            cool = 4;
          end else begin
            flush = 1'b0;
          end
        end
        tick();
      end
    end
    flush = 1'b0;
    word_ready = 1'b1;
    repeat (40) tick();
    check("rand_fifo_drained", src_q.size(), 0);
    check("rand_words_pending", exp_q.size(), 0);
    check("rand_words_seen", acc_log.size() > 100, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
